// File: rtl/mem_master.sv
// mem_master -- bridges a single-outstanding core load/store port onto
// separate read and write memory channels.
//
// Loads and word stores are issued as one memory access. Byte and half
// stores are done as read-modify-write: the containing word is read, the
// selected lanes are replaced, and the merged word is written back.
// Misaligned requests and the illegal size are answered with an error
// without touching memory. Any memory access that sees no ready for
// TIMEOUT cycles is abandoned and answered with an error.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   req_valid / req_ready       core request handshake (ready only in IDLE)
//   req_write, req_size,        request attributes, captured on acceptance
//   req_signed, req_addr,
//   req_wdata
//   resp_valid, resp_data,      one-cycle completion pulse with load data
//   resp_err                    and error flag
//   mem_rd_addr / mem_rd_valid  read request, word-aligned address
//   mem_rd_data / mem_rd_ready  read data, valid while ready is high
//   mem_wr_addr / mem_wr_data   write request, word-aligned address
//   mem_wr_valid / mem_wr_ready write handshake
module mem_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value at which one more ready-less cycle means timeout.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_r;
  logic        write_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [1:0]  lane_r;
  logic [31:0] wdata_r;
  logic [15:0] count_r;
  logic        turn_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_data_r;
  logic        rd_valid_r;
  logic        wr_valid_r;
  logic [31:0] rd_addr_r;
  logic [31:0] wr_addr_r;
  logic [31:0] wr_data_r;
  logic        req_bad_s;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sext);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = 8'(word >> {lane, 3'b000});
    half_v = 16'(word >> {lane[1], 4'b0000});
    case (size)
      2'b00:   res_v = {{24{sext & byte_v[7]}}, byte_v};
      2'b01:   res_v = {{16{sext & half_v[15]}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  // Replace the addressed lane of a memory word with right-aligned store data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] mask_v;
    logic [31:0] ins_v;
    case (size)
      2'b00: begin
        mask_v = 32'h0000_00FF << {lane, 3'b000};
        ins_v  = {24'h00_0000, data[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        mask_v = 32'h0000_FFFF << {lane[1], 4'b0000};
        ins_v  = {16'h0000, data[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask_v = 32'hFFFF_FFFF;
        ins_v  = data;
      end
    endcase
    return (word & ~mask_v) | (ins_v & mask_v);
  endfunction

  // Request is unserviceable: misaligned for its size, or illegal size.
  always_comb begin
    req_bad_s = 1'b0;
    case (req_size)
      2'b00:   req_bad_s = 1'b0;
      2'b01:   req_bad_s = req_addr[0];
      2'b10:   req_bad_s = |req_addr[1:0];
      default: req_bad_s = 1'b1;
    endcase
  end

  assign req_ready    = (state_r == IDLE);
  assign resp_valid   = resp_valid_r;
  assign resp_err     = resp_err_r;
  assign resp_data    = resp_data_r;
  assign mem_rd_valid = rd_valid_r;
  assign mem_wr_valid = wr_valid_r;
  assign mem_rd_addr  = rd_addr_r;
  assign mem_wr_addr  = wr_addr_r;
  assign mem_wr_data  = wr_data_r;

  // Main controller: request capture, memory handshakes, timeout, response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      write_r      <= 1'b0;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      lane_r       <= 2'b00;
      wdata_r      <= 32'h0000_0000;
      count_r      <= 16'h0000;
      turn_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= 32'h0000_0000;
      rd_valid_r   <= 1'b0;
      wr_valid_r   <= 1'b0;
      rd_addr_r    <= 32'h0000_0000;
      wr_addr_r    <= 32'h0000_0000;
      wr_data_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r   <= req_write;
            size_r    <= req_size;
            signed_r  <= req_signed;
            lane_r    <= req_addr[1:0];
            wdata_r   <= req_wdata;
            rd_addr_r <= {req_addr[31:2], 2'b00};
            wr_addr_r <= {req_addr[31:2], 2'b00};
            count_r   <= 16'h0000;
            turn_r    <= 1'b0;
            if (req_bad_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_data_r  <= 32'h0000_0000;
            end else if (req_write && (req_size == 2'b10)) begin
              state_r    <= WRITE;
              wr_valid_r <= 1'b1;
              wr_data_r  <= req_wdata;
            end else begin
              // Loads, and sub-word stores which need the old word first.
              state_r    <= READ;
              rd_valid_r <= 1'b1;
            end
          end
        end

        READ: begin
          // Ready wins over a timeout that would fire on the same edge.
          if (mem_rd_ready) begin
            rd_valid_r <= 1'b0;
            count_r    <= 16'h0000;
            if (write_r) begin
              // The merged word is registered here and the write is raised
              // one cycle later, leaving an idle cycle between the read and
              // the write-back on the memory side.
              state_r   <= WRITE;
              wr_data_r <= merge_lanes(mem_rd_data, wdata_r, size_r, lane_r);
              turn_r    <= 1'b1;
            end else begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b0;
              resp_data_r  <= load_extract(mem_rd_data, size_r, lane_r, signed_r);
            end
          end else if (count_r == CNT_LAST) begin
            rd_valid_r   <= 1'b0;
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_data_r  <= 32'h0000_0000;
          end else begin
            count_r <= count_r + 16'h0001;
          end
        end

        WRITE: begin
          if (turn_r) begin
            turn_r     <= 1'b0;
            wr_valid_r <= 1'b1;
            count_r    <= 16'h0000;
          end else if (mem_wr_ready) begin
            wr_valid_r   <= 1'b0;
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
          end else if (count_r == CNT_LAST) begin
            wr_valid_r   <= 1'b0;
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_data_r  <= 32'h0000_0000;
          end else begin
            count_r <= count_r + 16'h0001;
          end
        end

        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_data_r  <= 32'h0000_0000;
        end

        default: begin
          state_r      <= IDLE;
          rd_valid_r   <= 1'b0;
          wr_valid_r   <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_data_r  <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Randomized self-checking bench for mem_master with a word-array memory
// model on the bench side and a byte-level reference model of the core port.
module tb_mem_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_rd_ready;

  always #5 clk = ~clk;

  mem_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mem_a   [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_init;
  logic        stall_rd;
  logic        stall_wr;
  int          fixed_delay;
  int          delay_r;
  int          wait_r;
  int          eff_delay;
  int          rd_beats, wr_beats, valid_cycles, overlap;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

  assign eff_delay    = (fixed_delay >= 0) ? fixed_delay : delay_r;
  assign mem_rd_ready = mem_rd_valid && !stall_rd && (wait_r >= eff_delay);
  assign mem_wr_ready = mem_wr_valid && !stall_wr && (wait_r >= eff_delay);
  assign mem_rd_data  = mem_a[mem_rd_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
      rd_beats     <= 0;
      wr_beats     <= 0;
      valid_cycles <= 0;
      overlap      <= 0;
      wait_r       <= 0;
      delay_r      <= 0;
      last_rd_addr <= 32'h0;
      last_wr_addr <= 32'h0;
      last_wr_data <= 32'h0;
    end else begin
      if (mem_wr_valid && mem_wr_ready) begin
        mem_a[mem_wr_addr[9:2]] <= mem_wr_data;
        wr_beats     <= wr_beats + 1;
        last_wr_addr <= mem_wr_addr;
        last_wr_data <= mem_wr_data;
      end
      if (mem_rd_valid && mem_rd_ready) begin
        rd_beats     <= rd_beats + 1;
        last_rd_addr <= mem_rd_addr;
      end
      if (mem_rd_valid || mem_wr_valid) valid_cycles <= valid_cycles + 1;
      if (mem_rd_valid && mem_wr_valid) overlap <= overlap + 1;
      if ((mem_rd_valid && mem_rd_ready) || (mem_wr_valid && mem_wr_ready)) begin
        wait_r  <= 0;
        delay_r <= int'($urandom_range(2, 0));
      end else if (mem_rd_valid || mem_wr_valid) begin
        wait_r <= wait_r + 1;
      end else begin
        wait_r <= 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Works byte by byte on a word array: what the core should see and what
  // the memory word should become.
  function automatic void ref_txn(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] e_data, output logic e_err,
                                  output int e_rd, output int e_wr, output logic [31:0] e_word);
    int nb, off;
    logic [31:0] word, val;
    nb     = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    off    = int'(a[1:0]);
    word   = ref_mem[a[9:2]];
    e_data = 32'h0;
    e_rd   = 0;
    e_wr   = 0;
    e_word = word;
    e_err  = (sz == 2'd3) || ((off % nb) != 0);
    if (e_err) return;
    if (!w) begin
      val = 32'h0;
      for (int k = 0; k < nb; k++)
        val = val | (((word >> (8 * (off + k))) & 32'hFF) << (8 * k));
      if (sg && nb < 4 && val[8 * nb - 1])
        val = val | ~((32'h1 << (8 * nb)) - 32'h1);
      e_data = val;
      e_rd   = 1;
    end else begin
      val = word;
      for (int k = 0; k < nb; k++)
        val = (val & ~(32'hFF << (8 * (off + k)))) |
              (((wd >> (8 * k)) & 32'hFF) << (8 * (off + k)));
      e_word = val;
      ref_mem[a[9:2]] = val;
      e_rd = (nb < 4) ? 1 : 0;
      e_wr = 1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // Returns #1 after the acceptance edge with the request inputs scrambled.
  task automatic start_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    drive_req(w, sz, sg, a, wd);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Edges from acceptance (inclusive) until resp_valid is seen high.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("resp_seen", 32'(resp_valid), 32'd1);
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int extra, output logic [31:0] got);
    logic [31:0] e_data, e_word;
    logic e_err;
    int e_rd, e_wr, lat, rd0, wr0, vc0, exp_lat;
    ref_txn(w, sz, sg, a, wd, e_data, e_err, e_rd, e_wr, e_word);
    rd0 = rd_beats;
    wr0 = wr_beats;
    vc0 = valid_cycles;
    start_req(w, sz, sg, a, wd);
    wait_resp(lat);
    got = resp_data;
    check_eq("resp_data", resp_data, e_data);
    check_eq("resp_err", 32'(resp_err), 32'(e_err));
    if (extra >= 0) begin
      exp_lat = e_err ? 1 : (((e_rd == 1 && e_wr == 1) ? 4 : 2) + extra);
      check_eq("latency", 32'(lat), 32'(exp_lat));
    end else begin
      check_eq("latency_bound", 32'(lat <= 12), 32'd1);
    end
    @(posedge clk);
    #1;
    check_eq("resp_pulse", 32'(resp_valid), 32'd0);
    check_eq("rd_beats", 32'(rd_beats - rd0), 32'(e_rd));
    check_eq("wr_beats", 32'(wr_beats - wr0), 32'(e_wr));
    if (e_err) check_eq("no_mem_valid", 32'(valid_cycles - vc0), 32'd0);
    if (e_rd == 1) check_eq("rd_addr", last_rd_addr, {a[31:2], 2'b00});
    if (e_wr == 1) begin
      check_eq("wr_addr", last_wr_addr, {a[31:2], 2'b00});
      check_eq("wr_data", last_wr_data, e_word);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    int lat, vc0, rd0, wr0, seen;
    reset = 1'b1; mem_init = 1'b1; stall_rd = 1'b0; stall_wr = 1'b0; fixed_delay = 0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'h0);
    check_eq("rst_mem_valids", 32'({mem_rd_valid, mem_wr_valid}), 32'd0);
    check_eq("rst_mem_wr_data", mem_wr_data, 32'h0);
    @(negedge clk);
    mem_init = 1'b0;
    reset    = 1'b0;

    // directed vectors, zero-wait memory
    txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, got);
    txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, got);
    check_eq("word_load_0x100", got, 32'hDEAD_BEEF);
    txn(1'b1, 2'b10, 1'b0, 32'h40, 32'h80FF_7F01, 0, got);
    txn(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 0, got);
    check_eq("sbyte_0x43", got, 32'hFFFF_FF80);
    txn(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 0, got);
    check_eq("uhalf_0x42", got, 32'h0000_80FF);
    txn(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 0, got);
    check_eq("sbyte_0x40", got, 32'h0000_0001);
    txn(1'b1, 2'b10, 1'b0, 32'h40, 32'h1122_3344, 0, got);
    txn(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00AB, 0, got);
    check_eq("rmw_byte_0x41", last_wr_data, 32'h1122_AB44);
    txn(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, got);
    txn(1'b1, 2'b10, 1'b0, 32'h102, 32'h5555_AAAA, 0, got);
    txn(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, got);

    // randomized traffic with random memory wait states
    fixed_delay = -1;
    for (int i = 0; i < 60; i++)
      txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, -1, got);
    fixed_delay = 0;

    // read timeout: valid held TO cycles, then error
    stall_rd = 1'b1;
    vc0 = valid_cycles; rd0 = rd_beats;
    start_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    wait_resp(lat);
    check_eq("rd_to_err", 32'(resp_err), 32'd1);
    check_eq("rd_to_data", resp_data, 32'h0);
    check_eq("rd_to_latency", 32'(lat), 32'(TO + 1));
    check_eq("rd_to_valid_cycles", 32'(valid_cycles - vc0), 32'(TO));
    check_eq("rd_to_mem_valid", 32'(mem_rd_valid), 32'd0);
    check_eq("rd_to_beats", 32'(rd_beats - rd0), 32'd0);
    stall_rd = 1'b0;
    @(posedge clk);
    #1;

    // write timeout during a byte read-modify-write: memory left untouched
    stall_wr = 1'b1;
    wr0 = wr_beats;
    start_req(1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0055);
    wait_resp(lat);
    check_eq("wr_to_err", 32'(resp_err), 32'd1);
    check_eq("wr_to_latency", 32'(lat), 32'(TO + 3));
    check_eq("wr_to_beats", 32'(wr_beats - wr0), 32'd0);
    stall_wr = 1'b0;
    @(posedge clk);
    #1;
    txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, got);

    // ready arriving on the last allowed cycle completes normally
    fixed_delay = TO - 1;
    txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, TO - 1, got);
    fixed_delay = 0;

    // reset in the middle of a read
    stall_rd = 1'b1;
    start_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rd_valid_pre_reset", 32'(mem_rd_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_rd_valid", 32'(mem_rd_valid), 32'd0);
    check_eq("rst_mid_req_ready", 32'(req_ready), 32'd1);
    stall_rd = 1'b0;
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    check_eq("rst_mid_no_resp", 32'(seen), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("accept_after_reset", 32'(req_ready), 32'd0);
    wait_resp(lat);
    check_eq("post_reset_data", resp_data, ref_mem[8'd16]);
    check_eq("post_reset_err", 32'(resp_err), 32'd0);
    check_eq("post_reset_latency", 32'(lat), 32'd2);
    @(posedge clk);
    #1;

    check_eq("rd_wr_overlap", 32'(overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, max cycles waiting on a memory ready before abort (legal 1..65535).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  core request present.
REQ-005 SHALL have port: req_ready  output  1  request accepted at edge where req_valid && req_ready.
REQ-006 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port: req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_data  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port: resp_err  output  1  qualifies resp_valid; misaligned, illegal size or timeout.
REQ-014 SHALL have port: mem_wr_addr / mem_wr_data  output  32 each  write address / data.
REQ-015 SHALL have port: mem_wr_valid  output  1; mem_wr_ready  input  1  write handshake.
REQ-016 SHALL have port: mem_rd_addr  output  32; mem_rd_valid  output  1  read request.
REQ-017 SHALL have port: mem_rd_data  input  32; mem_rd_ready  input  1  read data, valid while ready=1.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = (state == IDLE), combinational.
REQ-019 SHALL capture req_write, req_size, req_signed, req_addr, req_wdata at acceptance; later changes ignored until next acceptance.
REQ-020 SHALL drive mem_*_addr as captured address with bits [1:0] forced to 00.
REQ-021 Misalignment SHALL be: half with addr[0]=1, word with addr[1:0]!=00; misaligned or size 11 -> IDLE to RESP, resp_err=1, no memory valid asserted.
REQ-022 Load or sub-word store SHALL go IDLE -> READ (mem_rd_valid=1); word store SHALL go IDLE -> WRITE (mem_wr_valid=1).
REQ-023 mem_*_valid SHALL be registered, held high until the matching ready is sampled 1, then deasserted at that same edge.
REQ-024 mem_rd_valid and mem_wr_valid SHALL never be high in the same cycle.
REQ-025 READ on ready: load -> RESP with extracted data; sub-word store -> WRITE with merged word (original word, selected lanes replaced).
REQ-026 Lanes SHALL be little-endian: byte k at bits 8k+7:8k; half at addr[1]=h at bits 16h+15:16h.
REQ-027 Loads SHALL place result in low bits, upper bits zero-extended or sign-extended from the top bit of the selected lane per req_signed; word loads pass unmodified.
REQ-028 WRITE on mem_wr_ready -> RESP, resp_data=0.
REQ-029 A cycle counter SHALL clear on entry to READ/WRITE, increment each cycle without ready; on reaching TIMEOUT, drop valid, go RESP with resp_err=1, resp_data=0.
REQ-030 RESP SHALL last exactly one cycle with resp_valid=1, then IDLE; resp_valid, resp_err, resp_data 0 in all other states.
REQ-031 Latency from acceptance edge to resp_valid high: word load/store 2 cycles, sub-word store 4, error 1 (zero-wait memory).
REQ-032 Ready seen in the same cycle the counter hits TIMEOUT SHALL take priority (normal completion).

Reset
REQ-033 reset SHALL asynchronously force state IDLE, counter 0, and all outputs 0 (req_ready=1 follows IDLE), including mid-transaction.
REQ-034 After reset deassertion the first request SHALL be acceptable at the next rising edge.

Verification
REQ-035 Word store addr 0x100 data 0xDEADBEEF, then word load 0x100 -> resp_data 0xDEADBEEF, err 0, each 2 cycles after acceptance.
REQ-036 Memory word 0x80FF7F01 at 0x40: signed byte load 0x43 -> 0xFFFFFF80; unsigned half load 0x42 -> 0x000080FF; signed byte 0x40 -> 0x00000001.
REQ-037 Byte store 0xAB to 0x41 over 0x11223344 -> one read then one write of 0x1122AB44; resp_valid 4 cycles after acceptance.
REQ-038 Half load 0x101, word store 0x102, size 11 -> resp_err=1 after 1 cycle, no mem valid ever high.
REQ-039 Ready held 0, TIMEOUT=4 -> valid drops after 4 cycles, resp_err=1; reset asserted mid-READ -> mem_rd_valid 0 immediately, no resp_valid.
